// File: rtl/hwmem_req_ctrl.sv
// Request front-end for the dual-port HWmem word RAM: registered stores, credit-limited loads, in-order response FIFO.
// Define HWMEM_FWD_EN to forward write-stage bytes into a colliding load instead of stalling it for one cycle.
module hwmem_req_ctrl #(
   parameter int unsigned LINES      = 4096,
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter int unsigned RESP_DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [31:0]              req_addr,
   input  logic [3:0]               req_be,
   input  logic [31:0]              req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_rdata,
   output logic                     rsp_err,
   output logic                     mem_en_a,
   output logic [$clog2(LINES)-1:0] mem_addr_a,
   input  logic [31:0]              mem_data_out_a,
   output logic [$clog2(LINES)-1:0] mem_addr_b,
   output logic [3:0]               mem_be_b,
   output logic [31:0]              mem_data_in_b
);
   localparam int unsigned   AW   = $clog2(LINES);
   localparam int unsigned   PW   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int unsigned   CW   = $clog2(RESP_DEPTH + 1) + 1;
   localparam logic [32:0]   SPAN = 33'(LINES) << 2;
   localparam logic [PW-1:0] LAST = PW'(RESP_DEPTH - 1);

   logic [31:0]   req_off;
   logic          req_in_range;
   logic [AW-1:0] req_idx;
   logic          unused_off;

   logic          wr_vld_q, wr_vld_d;
   logic [AW-1:0] wr_idx_q, wr_idx_d;
   logic [3:0]    wr_be_q, wr_be_d;
   logic [31:0]   wr_data_q, wr_data_d;

   logic          ld_vld_q, ld_vld_d;
   logic          ld_err_q, ld_err_d;
`ifdef HWMEM_FWD_EN
   logic [3:0]    fwd_be_q, fwd_be_d;
   logic [31:0]   fwd_data_q, fwd_data_d;
`endif

   logic [31:0]   fifo_data_q [RESP_DEPTH];
   logic          fifo_err_q  [RESP_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          st_fire, ld_fire, hazard, ld_stall, credit_ok, push, pop;
   logic [CW-1:0] busy;
   logic [31:0]   ld_data;

   assign req_off      = req_addr - BASE_ADDR;
   assign req_in_range = (req_addr >= BASE_ADDR) && ({1'b0, req_off} < SPAN);
   assign req_idx      = req_off[AW+1:2];
   assign unused_off   = ^{req_off[31:AW+2], req_off[1:0]};

   // A load colliding with the word being committed this cycle would read undefined RAM data.
   assign hazard = wr_vld_q & req_in_range & (req_idx == wr_idx_q);
`ifdef HWMEM_FWD_EN
   assign ld_stall = 1'b0;
`else
   assign ld_stall = hazard;
`endif

   assign pop       = rsp_valid & rsp_ready;
   assign push      = ld_vld_q;
   assign busy      = cnt_q + CW'(ld_vld_q) - CW'(pop);
   assign credit_ok = busy < CW'(RESP_DEPTH);
   assign req_ready = rst_n & (req_we | (credit_ok & ~ld_stall));
   assign st_fire   = req_valid & req_ready & req_we;
   assign ld_fire   = req_valid & req_ready & ~req_we;

   assign mem_en_a      = ld_fire & req_in_range;
   assign mem_addr_a    = mem_en_a ? req_idx : '0;
   assign mem_addr_b    = wr_idx_q;
   assign mem_data_in_b = wr_data_q;
   assign mem_be_b      = wr_vld_q ? wr_be_q : 4'b0000;

   always_comb begin
      wr_vld_d  = st_fire & req_in_range;
      wr_idx_d  = wr_idx_q;
      wr_be_d   = wr_be_q;
      wr_data_d = wr_data_q;
      if (st_fire & req_in_range) begin
         wr_idx_d  = req_idx;
         wr_be_d   = req_be;
         wr_data_d = req_wdata;
      end
      ld_vld_d = ld_fire;
      ld_err_d = ld_fire & ~req_in_range;
`ifdef HWMEM_FWD_EN
      fwd_be_d   = (ld_fire & hazard) ? wr_be_q : 4'b0000;
      fwd_data_d = wr_data_q;
`endif
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
      if (pop)  rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   // Returned RAM word, with the committing store's bytes laid over it on a collision.
   always_comb begin
      ld_data = mem_data_out_a;
`ifdef HWMEM_FWD_EN
      for (int b = 0; b < 4; b++) begin
         if (fwd_be_q[b]) ld_data[8*b +: 8] = fwd_data_q[8*b +: 8];
      end
`endif
      if (ld_err_q) ld_data = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_vld_q   <= 1'b0;
         wr_idx_q   <= '0;
         wr_be_q    <= '0;
         wr_data_q  <= '0;
         ld_vld_q   <= 1'b0;
         ld_err_q   <= 1'b0;
`ifdef HWMEM_FWD_EN
         fwd_be_q   <= '0;
         fwd_data_q <= '0;
`endif
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
      end else begin
         wr_vld_q   <= wr_vld_d;
         wr_idx_q   <= wr_idx_d;
         wr_be_q    <= wr_be_d;
         wr_data_q  <= wr_data_d;
         ld_vld_q   <= ld_vld_d;
         ld_err_q   <= ld_err_d;
`ifdef HWMEM_FWD_EN
         fwd_be_q   <= fwd_be_d;
         fwd_data_q <= fwd_data_d;
`endif
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wptr_q] <= ld_data;
         fifo_err_q[wptr_q]  <= ld_err_q;
      end
   end

   assign rsp_valid = (cnt_q != '0);
   assign rsp_rdata = rsp_valid ? fifo_data_q[rptr_q] : '0;
   assign rsp_err   = rsp_valid & fifo_err_q[rptr_q];

endmodule
